// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern transmitter and the sequence-detector chain.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } seq_state_t;

  localparam int         SEQ_WIDTH       = 4;
  localparam logic [3:0] SEQ_DEFAULT_PAT = 4'b1001;

endpackage

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a captured pattern out MSB-first, repeated
// rep_count+1 times, with GAP zero bits after each frame so a detector re-arms.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int WIDTH = SEQ_WIDTH,
  parameter int CNT_W = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pat_valid,
  output logic             pat_ready,
  input  logic [WIDTH-1:0] pat_data,
  input  logic [CNT_W-1:0] rep_count,
  output logic             out_bit,
  output logic             out_valid,
  output logic             busy,
  output logic             frame_done
);

  localparam int BIT_W = $clog2(WIDTH);
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  seq_state_t       state;
  logic [WIDTH-1:0] pat_reg;
  logic [WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0] reps_left;
  logic [BIT_W-1:0] bit_cnt;
  logic [GAP_W-1:0] gap_cnt;

  // shift_reg[WIDTH-1] is always the bit currently on out_bit; bit_cnt is its index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      pat_reg    <= '0;
      shift_reg  <= '0;
      reps_left  <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      out_bit    <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      pat_ready  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          out_valid <= 1'b0;
          out_bit   <= 1'b0;
          busy      <= 1'b0;
          pat_ready <= 1'b1;
          if (pat_valid && pat_ready) begin
            pat_reg   <= pat_data;
            shift_reg <= pat_data;
            reps_left <= rep_count;
            bit_cnt   <= BIT_LAST;
            out_valid <= 1'b1;
            out_bit   <= pat_data[WIDTH-1];
            busy      <= 1'b1;
            pat_ready <= 1'b0;
            state     <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (bit_cnt != '0) begin
            shift_reg  <= shift_reg << 1;
            bit_cnt    <= bit_cnt - 1'b1;
            out_bit    <= shift_reg[WIDTH-2];
            frame_done <= (bit_cnt == BIT_W'(1)) && (reps_left == '0);
          end else if (GAP > 0) begin
            state   <= ST_GAP;
            gap_cnt <= GAP_LAST;
            out_bit <= 1'b0;
          end else if (reps_left != '0) begin
            shift_reg <= pat_reg;
            bit_cnt   <= BIT_LAST;
            reps_left <= reps_left - 1'b1;
            out_bit   <= pat_reg[WIDTH-1];
          end else begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            busy      <= 1'b0;
            pat_ready <= 1'b1;
          end
        end

        ST_GAP: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
          end else if (reps_left != '0) begin
            state     <= ST_SHIFT;
            shift_reg <= pat_reg;
            bit_cnt   <= BIT_LAST;
            reps_left <= reps_left - 1'b1;
            out_bit   <= pat_reg[WIDTH-1];
          end else begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            busy      <= 1'b0;
            pat_ready <= 1'b1;
          end
        end

        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          out_bit   <= 1'b0;
          busy      <= 1'b0;
          pat_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
